multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle sequencer for the MIPS core; replaces single-cycle decode when datapath shares one ALU/memory.
//  Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
//  Drives per-cycle enables and mux selects for the PC, IR, register file, ALU and unified memory.
//  Stalls on a memory-ready handshake; latches illegal opcodes into a sticky HALT.
// PARAMETERS
//  RETIRE_W   32   width of retired-instruction counter (wraps modulo 2^RETIRE_W)
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  opcode         in   6   IR[31:26]; sampled only in DECODE
//  mem_ready      in   1   memory completes current access this cycle
//  pc_write       out  1   unconditional PC load
//  branch         out  1   PC load qualified by ALU zero (datapath ANDs)
//  pc_src         out  2   00 ALU result, 01 ALUOut reg, 10 jump target
//  iord           out  1   0 PC addresses memory, 1 ALUOut addresses memory
//  mem_read       out  1   memory read request
//  mem_write      out  1   memory write request
//  ir_write       out  1   load IR from memory data
//  reg_dst        out  1   1 rd, 0 rt
//  mem_to_reg     out  1   1 MDR, 0 ALUOut to register write data
//  reg_write      out  1   register file write enable
//  alu_src_a      out  1   0 PC, 1 register A
//  alu_src_b      out  2   00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  2   00 add, 01 sub, 10 funct-decoded (same coding as ALU control)
//  illegal_op     out  1   sticky; high while in HALT
//  retired_count  out  RETIRE_W  instructions completed since reset
// BEHAVIOUR
//  - Reset: state=FETCH, retired_count=0, illegal_op=0. Reset mid-instruction aborts it; no count.
//  - Defaults all outputs 0; decoded from registered state (Moore) except mem_ready gating below.
//  - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00;
//    ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
//    000000->RTYPE_EX, 100011/101011->MEM_ADR, 001000->ADDI_EX, 000100->BEQ, 000010->JUMP, other->HALT.
//  - RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPE_WB (reg_dst=1, mem_to_reg=0, reg_write=1) -> FETCH.
//  - MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD if lw, MEM_WR if sw (opcode held stable by IR).
//  - MEM_RD: iord=1, mem_read=1; stay until mem_ready -> MEM_WB (reg_dst=0, mem_to_reg=1, reg_write=1) -> FETCH.
//  - MEM_WR: iord=1, mem_write=1; stay until mem_ready -> FETCH. mem_write held high through stall.
//  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB (reg_dst=0, mem_to_reg=0, reg_write=1) -> FETCH.
//  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01 -> FETCH.
//  - JUMP: pc_write=1, pc_src=10 -> FETCH.
//  - HALT: illegal_op=1, all enables 0; absorbing until reset.
//  - retired_count += 1 on every transition into FETCH from RTYPE_WB/MEM_WB/MEM_WR/ADDI_WB/BEQ/JUMP.
//  - Latency with mem_ready tied 1: beq/j 3, R/addi/sw 4, lw 5 cycles; each stall cycle adds 1.
//  - Never more than one of mem_read/mem_write high; reg_write and pc_write never high in HALT.
// STRUCTURE
//  - Shared package/header mips_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J),
//    ALUOp codes, alu_src_b and pc_src encodings, state enum (4-bit) -- shared with the ALU control and datapath.
//  - One sub-module natural: mcfsm_output_decode (pure combinational state -> control word).
//  - Top keeps the state register, next-state logic and retire counter.
// TESTING
//  - Reset then R-type (000000), mem_ready=1 -> states F,D,RX,RWB; reg_write=1,reg_dst=1 in cycle 4; count=1.
//  - lw (100011) with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; mem_read held, reg_write only in MEM_WB.
//  - sw (101011), then beq (000100), then j (000010) -> 4,3,3 cycles; branch=1 only in BEQ; pc_src=10 in JUMP; count=3.
//  - Opcode 111111 in DECODE -> HALT next cycle, illegal_op=1, no enables for 10 cycles; reset -> FETCH, illegal_op=0.
//  - Assert reset during MEM_WR stall -> next cycle FETCH, mem_write=0, count unchanged at 0.
//  - RETIRE_W=4, run 17 j instructions -> retired_count wraps to 1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: opcodes, ALU/mux encodings,
// sequencer state encoding and the per-cycle control word.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_RTYPE_EX,
      S_RTYPE_WB,
      S_MEM_ADR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_ADDI_EX,
      S_ADDI_WB,
      S_BEQ,
      S_JUMP,
      S_HALT
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal_op;
   } ctrl_t;

   // Last state of every instruction; leaving it for FETCH retires one.
   function automatic logic is_retire(state_t s);
      return (s == S_RTYPE_WB) || (s == S_MEM_WB) ||
             (s == S_MEM_WR) || (s == S_ADDI_WB) ||
             (s == S_BEQ) || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Sequencer <-> datapath bundle: instruction/memory status in,
// per-cycle enables and mux selects out.
interface multicycle_control_fsm_if #(
   parameter int RETIRE_W = 32
);
   logic [5:0]          opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                branch;
   logic [1:0]          pc_src;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic                illegal_op;
   logic [RETIRE_W-1:0] retired_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, branch, pc_src, iord, mem_read, mem_write,
      output ir_write, reg_dst, mem_to_reg, reg_write,
      output alu_src_a, alu_src_b, alu_op, illegal_op, retired_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, branch, pc_src, iord, mem_read, mem_write,
      input  ir_write, reg_dst, mem_to_reg, reg_write,
      input  alu_src_a, alu_src_b, alu_op, illegal_op, retired_count
   );
endinterface

// File: rtl/mcfsm_output_decode.sv
// Moore control word from the sequencer state; only FETCH looks
// at mem_ready so the PC/IR load exactly when the fetch completes.
module mcfsm_output_decode
   import mips_defs::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // State -> control word, every field defaulting to 0.
   always_comb begin
      ctrl = '0;
      unique case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_IMMSH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_RTYPE_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RTYPE_WB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_MEM_ADR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.branch    = 1'b1;
            ctrl.pc_src    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PCSRC_JUMP;
         end
         S_HALT: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencer: state register, next-state logic and
// retired-instruction counter; outputs come from mcfsm_output_decode.
module multicycle_control_fsm
   import mips_defs::*;
#(
   parameter int RETIRE_W = 32
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_control_fsm_if.master bus
);

   state_t              state;
   state_t              state_n;
   ctrl_t               ctrl;
   logic [RETIRE_W-1:0] retired;
   logic                retire;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_n;
   end

   // Next state; opcode is only meaningful while IR holds it.
   always_comb begin
      state_n = state;
      unique case (state)
         S_FETCH:    if (bus.mem_ready) state_n = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:    state_n = S_RTYPE_EX;
               OP_LW, OP_SW: state_n = S_MEM_ADR;
               OP_ADDI:     state_n = S_ADDI_EX;
               OP_BEQ:      state_n = S_BEQ;
               OP_J:        state_n = S_JUMP;
               default:     state_n = S_HALT;
            endcase
         end
         S_RTYPE_EX: state_n = S_RTYPE_WB;
         S_MEM_ADR:
            state_n = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (bus.mem_ready) state_n = S_MEM_WB;
         S_MEM_WR:   if (bus.mem_ready) state_n = S_FETCH;
         S_ADDI_EX:  state_n = S_ADDI_WB;
         S_RTYPE_WB, S_MEM_WB, S_ADDI_WB,
         S_BEQ, S_JUMP: state_n = S_FETCH;
         S_HALT:     state_n = S_HALT;
         default:    state_n = S_HALT;
      endcase
   end

   assign retire = is_retire(state) && (state_n == S_FETCH);

   // Retired-instruction counter, wraps modulo 2^RETIRE_W.
   always_ff @(posedge clk) begin
      if (reset)       retired <= '0;
      else if (retire) retired <= retired + RETIRE_W'(1);
   end

   mcfsm_output_decode u_dec (
      .state     (state),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.branch        = ctrl.branch;
   assign bus.pc_src        = ctrl.pc_src;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.illegal_op    = ctrl.illegal_op;
   assign bus.retired_count = retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table with a
// scoreboard queue; a RETIRE_W=4 copy shares stimulus to check wrap.
module tb_multicycle_control_fsm;

   // {pc_write,branch,pc_src,iord,mem_read,mem_write,ir_write,
   //  reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,illegal_op}
   localparam logic [16:0] W_F   = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
   localparam logic [16:0] W_FS  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
   localparam logic [16:0] W_D   = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
   localparam logic [16:0] W_RX  = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [16:0] W_RWB = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
   localparam logic [16:0] W_MA  = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [16:0] W_MRD = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] W_MWB = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
   localparam logic [16:0] W_MWR = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
   localparam logic [16:0] W_AWB = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_0;
   localparam logic [16:0] W_BEQ = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
   localparam logic [16:0] W_JMP = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] W_HLT = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_1;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        mr;
      logic        chk;
      logic [16:0] exp;
      int unsigned cnt;
      string       tag;
   } vec_t;

   typedef struct {
      logic        chk;
      logic [16:0] exp;
      int unsigned cnt;
      string       tag;
   } exp_t;

   bit   clk = 1'b1;
   logic reset;
   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int unsigned rc = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm_if #(.RETIRE_W(32)) b32 ();
   multicycle_control_fsm_if #(.RETIRE_W(4))  b4 ();

   multicycle_control_fsm #(.RETIRE_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b32.master)
   );

   multicycle_control_fsm #(.RETIRE_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4.master)
   );

   wire [16:0] act32 = {b32.pc_write, b32.branch, b32.pc_src,
      b32.iord, b32.mem_read, b32.mem_write, b32.ir_write,
      b32.reg_dst, b32.mem_to_reg, b32.reg_write, b32.alu_src_a,
      b32.alu_src_b, b32.alu_op, b32.illegal_op};
   wire [16:0] act4 = {b4.pc_write, b4.branch, b4.pc_src,
      b4.iord, b4.mem_read, b4.mem_write, b4.ir_write,
      b4.reg_dst, b4.mem_to_reg, b4.reg_write, b4.alu_src_a,
      b4.alu_src_b, b4.alu_op, b4.illegal_op};

   task automatic add(input logic r, input logic [5:0] op,
                      input logic mr, input logic [16:0] e,
                      input string t);
      vec_t v;
      v.rst = r; v.op = op; v.mr = mr; v.chk = 1'b1;
      v.exp = e; v.cnt = rc; v.tag = t;
      vecs.push_back(v);
   endtask

   task automatic seq_r();
      add(0, 6'b000000, 1, W_F,   "r_fetch");
      add(0, 6'b000000, 1, W_D,   "r_decode");
      add(0, 6'b000000, 1, W_RX,  "r_exec");
      add(0, 6'b000000, 1, W_RWB, "r_wb");
      rc++;
   endtask

   task automatic seq_lw(input int stalls);
      add(0, 6'b100011, 1, W_F,   "lw_fetch");
      add(0, 6'b100011, 1, W_D,   "lw_decode");
      add(0, 6'b100011, 1, W_MA,  "lw_adr");
      for (int i = 0; i < stalls; i++)
         add(0, 6'b100011, 0, W_MRD, "lw_rd_stall");
      add(0, 6'b100011, 1, W_MRD, "lw_rd");
      add(0, 6'b100011, 1, W_MWB, "lw_wb");
      rc++;
   endtask

   task automatic seq_sw();
      add(0, 6'b101011, 1, W_F,   "sw_fetch");
      add(0, 6'b101011, 1, W_D,   "sw_decode");
      add(0, 6'b101011, 1, W_MA,  "sw_adr");
      add(0, 6'b101011, 1, W_MWR, "sw_wr");
      rc++;
   endtask

   task automatic seq_beq();
      add(0, 6'b000100, 1, W_F,   "beq_fetch");
      add(0, 6'b000100, 1, W_D,   "beq_decode");
      add(0, 6'b000100, 1, W_BEQ, "beq_exec");
      rc++;
   endtask

   task automatic seq_j();
      add(0, 6'b000010, 1, W_F,   "j_fetch");
      add(0, 6'b000010, 1, W_D,   "j_decode");
      add(0, 6'b000010, 1, W_JMP, "j_exec");
      rc++;
   endtask

   task automatic seq_addi();
      add(0, 6'b001000, 1, W_F,   "addi_fetch");
      add(0, 6'b001000, 1, W_D,   "addi_decode");
      add(0, 6'b001000, 1, W_MA,  "addi_exec");
      add(0, 6'b001000, 1, W_AWB, "addi_wb");
      rc++;
   endtask

   task automatic check(input exp_t e);
      logic [3:0] c4;
      c4 = e.cnt[3:0];
      n_chk++;
      if (act32 === e.exp) n_pass++;
      else $display("FAIL %s ctrl32: got %b want %b", e.tag, act32, e.exp);
      n_chk++;
      if (act4 === e.exp) n_pass++;
      else $display("FAIL %s ctrl4: got %b want %b", e.tag, act4, e.exp);
      n_chk++;
      if (b32.retired_count === e.cnt) n_pass++;
      else $display("FAIL %s count32: got %0d want %0d", e.tag,
                    b32.retired_count, e.cnt);
      n_chk++;
      if (b4.retired_count === c4) n_pass++;
      else $display("FAIL %s count4: got %0d want %0d", e.tag,
                    b4.retired_count, c4);
   endtask

   initial begin
      vec_t v;
      exp_t e;
      vec_t v0;
      v0.rst = 1; v0.op = '0; v0.mr = 1; v0.chk = 0;
      v0.exp = '0; v0.cnt = 0; v0.tag = "power_on";
      vecs.push_back(v0);
      add(1, 6'b000000, 1, W_F, "reset_state");
      seq_r();
      seq_lw(2);
      seq_sw();
      seq_beq();
      seq_j();
      seq_addi();
      add(0, 6'b000000, 0, W_FS, "fetch_stall");
      add(0, 6'b111111, 1, W_F,  "ill_fetch");
      add(0, 6'b111111, 1, W_D,  "ill_decode");
      for (int i = 0; i < 10; i++)
         add(0, 6'(i * 7), 1'(i), W_HLT, "halt");
      add(1, 6'b000000, 1, W_HLT, "halt_reset");
      rc = 0;
      add(0, 6'b101011, 1, W_F,   "abort_fetch");
      add(0, 6'b101011, 1, W_D,   "abort_decode");
      add(0, 6'b101011, 1, W_MA,  "abort_adr");
      add(0, 6'b101011, 0, W_MWR, "abort_wr_stall");
      add(1, 6'b101011, 0, W_MWR, "abort_wr_reset");
      add(0, 6'b101011, 0, W_FS,  "abort_refetch");
      for (int i = 0; i < 17; i++) seq_j();
      add(0, 6'b000000, 0, W_FS,  "wrap_final");

      foreach (vecs[i]) begin
         v = vecs[i];
         reset = v.rst;
         b32.opcode = v.op;  b4.opcode = v.op;
         b32.mem_ready = v.mr; b4.mem_ready = v.mr;
         e.chk = v.chk; e.exp = v.exp; e.cnt = v.cnt; e.tag = v.tag;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         if (e.chk) check(e);
         @(posedge clk);
         #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
